// File: rtl/l2c_lookup_pkg.sv
// Shared L2 lookup geometry, FSM encoding and address field helpers.
// Optional hit/miss counters are enabled with L2C_LOOKUP_STAT_EN.
package l2c_lookup_pkg;
    localparam int L2C_WAY_NUM = 4;
    localparam int L2C_ADDR_W  = 32;
    localparam int L2C_INDEX_W = 9;
    localparam int L2C_DATA_W  = 256;
    localparam int L2C_OFF_W   = $clog2(L2C_DATA_W / 8);
    localparam int L2C_TAG_W   = L2C_ADDR_W - L2C_INDEX_W - L2C_OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WR     = 3'd2,
        ST_MISS   = 3'd3,
        ST_FILL   = 3'd4,
        ST_RSP    = 3'd5
    } l2c_state_e;

    function automatic logic [L2C_TAG_W-1:0] l2c_tag(input logic [L2C_ADDR_W-1:0] a);
        return a[L2C_ADDR_W-1 -: L2C_TAG_W];
    endfunction

    function automatic logic [L2C_INDEX_W-1:0] l2c_index(input logic [L2C_ADDR_W-1:0] a);
        return a[L2C_OFF_W +: L2C_INDEX_W];
    endfunction

    function automatic logic [L2C_OFF_W-1:0] l2c_offset(input logic [L2C_ADDR_W-1:0] a);
        return a[L2C_OFF_W-1:0];
    endfunction
endpackage

// File: rtl/l2c_way_sel.sv
// Tag compare across all ways, lowest-hit / lowest-invalid encode and victim mux.
module l2c_way_sel #(
    parameter int WAY_NUM = 4,
    parameter int TAG_W   = 18,
    parameter int DATA_W  = 256,
    parameter int WAY_W   = 2
) (
    input  logic [WAY_NUM*TAG_W-1:0]  i_rd_tag_pack,
    input  logic [WAY_NUM-1:0]        i_rd_valid_pack,
    input  logic [WAY_NUM-1:0]        i_rd_dirty_pack,
    input  logic [WAY_NUM*DATA_W-1:0] i_rd_data_pack,
    input  logic [TAG_W-1:0]          i_tag,
    input  logic [WAY_W-1:0]          i_rr_ptr,
    output logic                      o_hit,
    output logic [WAY_W-1:0]          o_hit_way,
    output logic [DATA_W-1:0]         o_hit_data,
    output logic [WAY_W-1:0]          o_vic_way,
    output logic                      o_vic_by_ptr,
    output logic [TAG_W-1:0]          o_vic_tag,
    output logic                      o_vic_dirty,
    output logic [DATA_W-1:0]         o_vic_data
);
    logic [WAY_NUM-1:0] w_hit_vec;
    logic [WAY_W-1:0]   w_inv_way;
    logic               w_has_inv;

    for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
        assign w_hit_vec[g] = i_rd_valid_pack[g] && (i_rd_tag_pack[g*TAG_W +: TAG_W] == i_tag);
    end

    // Scan from the top so the lowest matching way is the one left standing.
    always_comb begin
        o_hit_way = '0;
        w_inv_way = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (w_hit_vec[w])        o_hit_way = WAY_W'(w);
            if (!i_rd_valid_pack[w]) w_inv_way = WAY_W'(w);
        end
    end

    assign o_hit        = |w_hit_vec;
    assign w_has_inv    = ~&i_rd_valid_pack;
    assign o_vic_way    = w_has_inv ? w_inv_way : i_rr_ptr;
    assign o_vic_by_ptr = !w_has_inv;
    assign o_hit_data   = i_rd_data_pack[int'(o_hit_way)*DATA_W +: DATA_W];
    assign o_vic_tag    = i_rd_tag_pack[int'(o_vic_way)*TAG_W +: TAG_W];
    assign o_vic_data   = i_rd_data_pack[int'(o_vic_way)*DATA_W +: DATA_W];
    assign o_vic_dirty  = i_rd_valid_pack[o_vic_way] & i_rd_dirty_pack[o_vic_way];
endmodule

// File: rtl/l2c_lookup.sv
// L2 request-side controller: lookup, write-hit update, miss handoff and refill install.
// Optional hit/miss statistics counters are enabled with L2C_LOOKUP_STAT_EN.
module l2c_lookup
    import l2c_lookup_pkg::*;
#(
    parameter int WAY_NUM = L2C_WAY_NUM,
    parameter int ADDR_W  = L2C_ADDR_W,
    parameter int INDEX_W = L2C_INDEX_W,
    parameter int DATA_W  = L2C_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst_,
    input  logic                                 req,
    output logic                                 req_rdy,
    input  logic                                 req_rw,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic [DATA_W-1:0]                    req_wr_data,
    output logic                                 rsp_valid,
    output logic                                 rsp_hit,
    output logic [DATA_W-1:0]                    rsp_rd_data,
    output logic                                 miss_valid,
    input  logic                                 miss_ack,
    output logic [ADDR_W-1:0]                    miss_addr,
    output logic                                 miss_rw,
    output logic                                 miss_victim_dirty,
    output logic [ADDR_W-1:0]                    miss_victim_addr,
    output logic [DATA_W-1:0]                    miss_victim_data,
    input  logic                                 fill_valid,
    input  logic [DATA_W-1:0]                    fill_data,
`ifdef L2C_LOOKUP_STAT_EN
    output logic [31:0]                          stat_hit_cnt,
    output logic [31:0]                          stat_miss_cnt,
    input  logic                                 stat_clr,
`endif
    output logic                                 rw_req,
    output logic [INDEX_W-1:0]                   rw_index,
    output logic [WAY_NUM-1:0]                   wr_en_pack,
    output logic [WAY_NUM*(ADDR_W-INDEX_W-$clog2(DATA_W/8))-1:0] wr_tag_pack,
    output logic [WAY_NUM-1:0]                   wr_valid_pack,
    output logic [WAY_NUM-1:0]                   wr_dirty_pack,
    output logic [WAY_NUM*DATA_W-1:0]            wr_data_pack,
    input  logic                                 rw_rdy,
    input  logic [WAY_NUM*(ADDR_W-INDEX_W-$clog2(DATA_W/8))-1:0] rd_tag_pack,
    input  logic [WAY_NUM-1:0]                   rd_valid_pack,
    input  logic [WAY_NUM-1:0]                   rd_dirty_pack,
    input  logic [WAY_NUM*DATA_W-1:0]            rd_data_pack
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    l2c_state_e          r_state, w_state_nxt;
    logic                r_rw;
    logic [LINE_W-1:0]   r_line;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_hit;
    logic [WAY_W-1:0]    r_way;
    logic [WAY_W-1:0]    r_rr;
    logic [TAG_W-1:0]    r_vic_tag;
    logic                r_vic_dirty;
    logic [DATA_W-1:0]   r_vic_data;
    logic [DATA_W-1:0]   r_rd_data;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way, w_vic_way;
    logic [DATA_W-1:0]   w_hit_data, w_vic_data;
    logic                w_vic_by_ptr, w_vic_dirty;
    logic [TAG_W-1:0]    w_vic_tag;
    logic                w_wr_dirty;
    logic [DATA_W-1:0]   w_wr_data;
    logic [WAY_NUM-1:0]  w_way_oh;
    logic                w_unused_off;

    assign w_tag        = r_line[LINE_W-1 -: TAG_W];
    assign w_index      = r_line[INDEX_W-1:0];
    assign w_way_oh     = WAY_NUM'(1) << r_way;
    assign w_unused_off = ^req_addr[OFF_W-1:0];

    l2c_way_sel #(
        .WAY_NUM(WAY_NUM), .TAG_W(TAG_W), .DATA_W(DATA_W), .WAY_W(WAY_W)
    ) u_way_sel (
        .i_rd_tag_pack   (rd_tag_pack),
        .i_rd_valid_pack (rd_valid_pack),
        .i_rd_dirty_pack (rd_dirty_pack),
        .i_rd_data_pack  (rd_data_pack),
        .i_tag           (w_tag),
        .i_rr_ptr        (r_rr),
        .o_hit           (w_hit),
        .o_hit_way       (w_hit_way),
        .o_hit_data      (w_hit_data),
        .o_vic_way       (w_vic_way),
        .o_vic_by_ptr    (w_vic_by_ptr),
        .o_vic_tag       (w_vic_tag),
        .o_vic_dirty     (w_vic_dirty),
        .o_vic_data      (w_vic_data)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: if (req) begin
                    r_rw    <= req_rw;
                    r_line  <= req_addr[ADDR_W-1:OFF_W];
                    r_wdata <= req_wr_data;
                end
                ST_LOOKUP: if (rw_rdy) begin
                    r_hit       <= w_hit;
                    r_way       <= w_hit ? w_hit_way : w_vic_way;
                    r_vic_tag   <= w_vic_tag;
                    r_vic_dirty <= w_vic_dirty;
                    r_vic_data  <= w_vic_data;
                    if (w_hit) r_rd_data <= w_hit_data;
                    // Pointer only advances when it actually chose the victim.
                    if (!w_hit && w_vic_by_ptr)
                        r_rr <= (r_rr == WAY_W'(WAY_NUM - 1)) ? '0 : r_rr + WAY_W'(1);
                end
                ST_FILL: if (fill_valid && rw_rdy) r_rd_data <= fill_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rw_req      = 1'b0;
        wr_en_pack  = '0;
        w_wr_dirty  = 1'b0;
        w_wr_data   = r_wdata;
        case (r_state)
            ST_IDLE:   if (req) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                rw_req = 1'b1;
                if (rw_rdy) w_state_nxt = !w_hit ? ST_MISS : (r_rw ? ST_WR : ST_RSP);
            end
            ST_WR: begin
                rw_req     = 1'b1;
                wr_en_pack = w_way_oh;
                w_wr_dirty = 1'b1;
                if (rw_rdy) w_state_nxt = ST_RSP;
            end
            ST_MISS:   if (miss_ack) w_state_nxt = r_rw ? ST_WR : ST_FILL;
            ST_FILL: if (fill_valid) begin
                rw_req     = 1'b1;
                wr_en_pack = w_way_oh;
                w_wr_data  = fill_data;
                if (rw_rdy) w_state_nxt = ST_RSP;
            end
            ST_RSP:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // Keep the array untouched while reset is asserted, whatever state we are in.
        if (rst_) begin
            rw_req     = 1'b0;
            wr_en_pack = '0;
        end
    end

    assign req_rdy           = (r_state == ST_IDLE);
    assign rsp_valid         = (r_state == ST_RSP);
    assign rsp_hit           = (r_state == ST_RSP) && r_hit;
    assign rsp_rd_data       = r_rd_data;
    assign miss_valid        = (r_state == ST_MISS);
    assign miss_addr         = {r_line, {OFF_W{1'b0}}};
    assign miss_rw           = r_rw;
    assign miss_victim_dirty = r_vic_dirty;
    assign miss_victim_addr  = {r_vic_tag, w_index, {OFF_W{1'b0}}};
    assign miss_victim_data  = r_vic_data;

    assign rw_index      = w_index;
    assign wr_tag_pack   = {WAY_NUM{w_tag}};
    assign wr_valid_pack = '1;
    assign wr_dirty_pack = {WAY_NUM{w_wr_dirty}};
    assign wr_data_pack  = {WAY_NUM{w_wr_data}};

`ifdef L2C_LOOKUP_STAT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst_ || stat_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP && rw_rdy) begin
            if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)   r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign stat_hit_cnt  = r_hit_cnt;
    assign stat_miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_l2c_lookup.sv
// Scoreboard bench for l2c_lookup with a behavioural tag/data array model.
module tb_l2c_lookup;
    localparam int WAY_NUM = 4;
    localparam int ADDR_W  = 32;
    localparam int INDEX_W = 9;
    localparam int DATA_W  = 256;
    localparam int TAG_W   = 18;
    localparam int SETS    = 512;

    localparam logic [DATA_W-1:0] D_AA = {32{8'hAA}};
    localparam logic [DATA_W-1:0] D_55 = {32{8'h55}};
    localparam logic [DATA_W-1:0] D_11 = {32{8'h11}};
    localparam logic [DATA_W-1:0] D_22 = {32{8'h22}};
    localparam logic [DATA_W-1:0] D_33 = {32{8'h33}};
    localparam logic [DATA_W-1:0] D_44 = {32{8'h44}};
    localparam logic [DATA_W-1:0] D_66 = {32{8'h66}};
    localparam logic [DATA_W-1:0] D_77 = {32{8'h77}};
    localparam logic [DATA_W-1:0] D_88 = {32{8'h88}};
    localparam logic [DATA_W-1:0] D_0  = '0;

    logic clk = 1'b0;
    logic rst_ = 1'b1;
    logic req = 1'b0, req_rw = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wr_data = '0;
    logic req_rdy, rsp_valid, rsp_hit;
    logic [DATA_W-1:0] rsp_rd_data;
    logic miss_valid, miss_rw, miss_victim_dirty;
    logic miss_ack = 1'b0;
    logic [ADDR_W-1:0] miss_addr, miss_victim_addr;
    logic [DATA_W-1:0] miss_victim_data;
    logic fill_valid = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
    logic rw_req, rw_rdy;
    logic [INDEX_W-1:0] rw_index;
    logic [WAY_NUM-1:0] wr_en_pack, wr_valid_pack, wr_dirty_pack;
    logic [WAY_NUM*TAG_W-1:0] wr_tag_pack;
    logic [WAY_NUM*DATA_W-1:0] wr_data_pack;
    logic [WAY_NUM*TAG_W-1:0] rd_tag_pack = '0;
    logic [WAY_NUM-1:0] rd_valid_pack = '0, rd_dirty_pack = '0;
    logic [WAY_NUM*DATA_W-1:0] rd_data_pack = '0;
`ifdef L2C_LOOKUP_STAT_EN
    logic [31:0] stat_hit_cnt, stat_miss_cnt;
    logic stat_clr = 1'b0;
`endif

    l2c_lookup dut (
        .clk(clk), .rst_(rst_), .req(req), .req_rdy(req_rdy), .req_rw(req_rw),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_rd_data(rsp_rd_data),
        .miss_valid(miss_valid), .miss_ack(miss_ack), .miss_addr(miss_addr), .miss_rw(miss_rw),
        .miss_victim_dirty(miss_victim_dirty), .miss_victim_addr(miss_victim_addr),
        .miss_victim_data(miss_victim_data), .fill_valid(fill_valid), .fill_data(fill_data),
`ifdef L2C_LOOKUP_STAT_EN
        .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt), .stat_clr(stat_clr),
`endif
        .rw_req(rw_req), .rw_index(rw_index), .wr_en_pack(wr_en_pack), .wr_tag_pack(wr_tag_pack),
        .wr_valid_pack(wr_valid_pack), .wr_dirty_pack(wr_dirty_pack), .wr_data_pack(wr_data_pack),
        .rw_rdy(rw_rdy), .rd_tag_pack(rd_tag_pack), .rd_valid_pack(rd_valid_pack),
        .rd_dirty_pack(rd_dirty_pack), .rd_data_pack(rd_data_pack)
    );

    always #5 clk = ~clk;

    // Array model: writes complete in the request cycle, reads answer one cycle later.
    logic [TAG_W-1:0]  m_tag   [WAY_NUM][SETS];
    logic              m_val   [WAY_NUM][SETS];
    logic              m_dirty [WAY_NUM][SETS];
    logic [DATA_W-1:0] m_data  [WAY_NUM][SETS];
    logic arr_clr = 1'b1;
    logic rd_pend = 1'b0;
    logic [WAY_NUM-1:0] last_wr_en = '0, last_wr_dirty = '0;
    int wr_cnt = 0;
    int cyc = 0;

    assign rw_rdy = (rw_req && wr_en_pack != '0) || rd_pend;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_pend <= rw_req && (wr_en_pack == '0);
        if (arr_clr) begin
            for (int w = 0; w < WAY_NUM; w++)
                for (int s = 0; s < SETS; s++) begin
                    m_tag[w][s] <= '0; m_val[w][s] <= 1'b0;
                    m_dirty[w][s] <= 1'b0; m_data[w][s] <= '0;
                end
        end else if (rw_req && wr_en_pack == '0) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                rd_tag_pack[w*TAG_W +: TAG_W]    <= m_tag[w][rw_index];
                rd_valid_pack[w]                 <= m_val[w][rw_index];
                rd_dirty_pack[w]                 <= m_dirty[w][rw_index];
                rd_data_pack[w*DATA_W +: DATA_W] <= m_data[w][rw_index];
            end
        end else if (rw_req) begin
            for (int w = 0; w < WAY_NUM; w++)
                if (wr_en_pack[w]) begin
                    m_tag[w][rw_index]   <= wr_tag_pack[w*TAG_W +: TAG_W];
                    m_val[w][rw_index]   <= wr_valid_pack[w];
                    m_dirty[w][rw_index] <= wr_dirty_pack[w];
                    m_data[w][rw_index]  <= wr_data_pack[w*DATA_W +: DATA_W];
                end
            last_wr_en    <= wr_en_pack;
            last_wr_dirty <= wr_dirty_pack;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic              hit;
        logic              chk_data;
        logic [DATA_W-1:0] data;
        int                lat;
        int                t0;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_hit", DATA_W'(rsp_hit), DATA_W'(e.hit));
                if (e.chk_data) chk("rsp_rd_data", rsp_rd_data, e.data);
                if (e.lat != 0) chk("rsp_latency", DATA_W'(cyc - e.t0), DATA_W'(e.lat));
            end
        end
    end

    task automatic issue(input logic rw, input logic [31:0] a, input logic [DATA_W-1:0] wd,
                         input logic push, input logic ehit, input logic [DATA_W-1:0] ed,
                         input logic echk, input int elat);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_rdy && n < 100) begin @(negedge clk); n++; end
        chk("req_rdy_wait", DATA_W'(req_rdy), 1);
        req = 1'b1; req_rw = rw; req_addr = a; req_wr_data = wd;
        if (push) begin
            e.hit = ehit; e.chk_data = echk; e.data = ed; e.lat = elat; e.t0 = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("rsp_timeout", DATA_W'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic handle_miss(input logic rw, input logic [31:0] a, input logic vd,
                               input logic [31:0] va, input logic [DATA_W-1:0] vdata,
                               input int stall, input logic [DATA_W-1:0] fd,
                               input logic [WAY_NUM-1:0] way, input logic do_fill);
        int n = 0;
        while (!miss_valid && n < 50) begin @(negedge clk); n++; end
        chk("miss_valid", DATA_W'(miss_valid), 1);
        chk("miss_addr", DATA_W'(miss_addr), DATA_W'(a));
        chk("miss_rw", DATA_W'(miss_rw), DATA_W'(rw));
        chk("miss_victim_dirty", DATA_W'(miss_victim_dirty), DATA_W'(vd));
        chk("miss_victim_addr", DATA_W'(miss_victim_addr), DATA_W'(va));
        chk("miss_victim_data", miss_victim_data, vdata);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_miss_valid", DATA_W'(miss_valid), 1);
            chk("stall_victim_addr", DATA_W'(miss_victim_addr), DATA_W'(va));
            chk("stall_victim_data", miss_victim_data, vdata);
            chk("stall_req_rdy", DATA_W'(req_rdy), 0);
            chk("stall_rw_req", DATA_W'(rw_req), 0);
        end
        miss_ack = 1'b1;
        @(negedge clk);
        miss_ack = 1'b0;
        if (!do_fill) return;
        if (!rw) begin
            repeat (2) @(negedge clk);
            fill_data = fd; fill_valid = 1'b1;
            @(negedge clk);
            fill_valid = 1'b0;
            chk("fill_wr_way", DATA_W'(last_wr_en), DATA_W'(way));
            chk("fill_wr_dirty", DATA_W'((last_wr_dirty & way) != 0), 0);
        end else begin
            @(negedge clk);
            chk("wmiss_wr_way", DATA_W'(last_wr_en), DATA_W'(way));
            chk("wmiss_wr_dirty", DATA_W'((last_wr_dirty & way) != 0), 1);
        end
    endtask

    localparam logic [31:0] A_A = 32'h0000_1000, A_B = 32'h0000_5000, A_C = 32'h0000_9000;
    localparam logic [31:0] A_D = 32'h0000_D000, A_E = 32'h0001_1000, A_F = 32'h0001_5000;
    localparam logic [31:0] A_G = 32'h0001_9000, A_H = 32'h0002_1000;

    initial begin
        repeat (3) @(negedge clk);
        rst_ = 1'b0; arr_clr = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy", DATA_W'(req_rdy), 1);
        chk("rst_rsp_valid", DATA_W'(rsp_valid), 0);
        chk("rst_miss_valid", DATA_W'(miss_valid), 0);
        chk("rst_rw_req", DATA_W'(rw_req), 0);
        chk("rst_wr_en", DATA_W'(wr_en_pack), 0);

        // Cold read miss, then read hit, write hit, read back.
        issue(0, A_A, D_0, 1, 0, D_AA, 1, 0);
        handle_miss(0, A_A, 0, 32'h0000_1000, D_0, 0, D_AA, 4'b0001, 1);
        wait_done();
        issue(0, A_A, D_0, 1, 1, D_AA, 1, 3);
        wait_done();
        issue(1, A_A, D_55, 1, 1, D_0, 0, 4);
        wait_done();
        chk("whit_wr_way", DATA_W'(last_wr_en), 4'b0001);
        chk("whit_wr_dirty", DATA_W'(last_wr_dirty[0]), 1);
        issue(0, A_A, D_0, 1, 1, D_55, 1, 3);
        wait_done();

        // Fill ways 1..3 of the set through lowest-invalid allocation.
        issue(0, A_B, D_0, 1, 0, D_11, 1, 0);
        handle_miss(0, A_B, 0, 32'h0000_1000, D_0, 0, D_11, 4'b0010, 1);
        wait_done();
        issue(0, A_C, D_0, 1, 0, D_22, 1, 0);
        handle_miss(0, A_C, 0, 32'h0000_1000, D_0, 0, D_22, 4'b0100, 1);
        wait_done();
        issue(0, A_D, D_0, 1, 0, D_33, 1, 0);
        handle_miss(0, A_D, 0, 32'h0000_1000, D_0, 0, D_33, 4'b1000, 1);
        wait_done();

        // Full set: pointer victim way 0 (dirty), with a 10-cycle ack stall.
        issue(0, A_E, D_0, 1, 0, D_44, 1, 0);
        handle_miss(0, A_E, 1, A_A, D_55, 10, D_44, 4'b0001, 1);
        wait_done();

        // Write miss: pointer now 1, no fill wait, victim written dirty.
        issue(1, A_F, D_66, 1, 0, D_0, 0, 0);
        handle_miss(1, A_F, 0, A_B, D_11, 0, D_0, 4'b0010, 1);
        wait_done();
        issue(0, A_F, D_0, 1, 1, D_66, 1, 3);
        wait_done();

        // Reset while FILL has fill_valid pending; nothing may be written.
        begin
            int wc;
            issue(0, A_G, D_0, 0, 0, D_0, 0, 0);
            handle_miss(0, A_G, 0, A_C, D_22, 0, D_0, 4'b0100, 0);
            wc = wr_cnt;
            fill_data = D_77; fill_valid = 1'b1; rst_ = 1'b1;
            @(negedge clk);
            rst_ = 1'b0;
            chk("fillrst_req_rdy", DATA_W'(req_rdy), 1);
            chk("fillrst_rw_req", DATA_W'(rw_req), 0);
            chk("fillrst_miss_valid", DATA_W'(miss_valid), 0);
            repeat (2) begin
                @(negedge clk);
                chk("late_fill_rw_req", DATA_W'(rw_req), 0);
            end
            fill_valid = 1'b0;
            @(negedge clk);
            chk("fillrst_no_write", DATA_W'(wr_cnt), DATA_W'(wc));
        end

        // Array kept way 2; pointer was reset to 0.
        issue(0, A_C, D_0, 1, 1, D_22, 1, 3);
        wait_done();
        issue(0, A_H, D_0, 1, 0, D_88, 1, 0);
        handle_miss(0, A_H, 0, A_E, D_44, 0, D_88, 4'b0001, 1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
